// File: rtl/sparecell_tie_monitor.sv
// Watches the tie-low outputs of spare-cell macros: any bit seen high after the
// post-enable settle window raises a fault and is logged in sticky flags and an event counter.
module sparecell_tie_monitor #(
  parameter int NUM_SPARE     = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NUM_SPARE-1:0] spare_lo,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 rd_req,
  input  logic [1:0]           rd_sel,
  output logic [7:0]           rd_data,
  output logic                 rd_ack,
  output logic                 armed,
  output logic                 fault_irq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ARMED  = 2'd2,
    FAULT  = 2'd3
  } state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [NUM_SPARE-1:0] meta_q, sync_lo_q;
  logic [NUM_SPARE-1:0] sticky_q, sticky_d;
  logic [7:0]           settle_q, settle_d;
  logic [7:0]           count_q, count_d;
  logic                 fault_prev_q;
  logic                 any_fault, fault_rise, monitoring;
  logic                 rd_pend_q;
  logic [1:0]           rd_sel_q;
  logic [7:0]           rd_data_q, rd_data_d;
  logic                 rd_ack_q;

  assign any_fault  = |sync_lo_q;
  assign fault_rise = any_fault & ~fault_prev_q;
  assign monitoring = (state_q == ARMED) || (state_q == FAULT);

  assign armed     = monitoring;
  assign fault_irq = (state_q == FAULT);
  assign rd_data   = rd_data_q;
  assign rd_ack    = rd_ack_q;

  // NOTE: every flop below uses <= so all registers update from pre-edge values;
  // a blocking = here would let later statements see half-updated state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q       <= '0;
      sync_lo_q    <= '0;
      fault_prev_q <= 1'b0;
    end else begin
      meta_q       <= spare_lo;
      sync_lo_q    <= meta_q;
      fault_prev_q <= any_fault;
    end
  end

  // NOTE: each always_comb assigns all of its outputs first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SETTLE;
          settle_d = '0;
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) state_d = ARMED;
          else                         settle_d = settle_q + 8'd1;
        end
        ARMED: if (any_fault) state_d = FAULT;
        FAULT: if (clear && !any_fault) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Clear is applied first so a coincident fault sample or edge still lands.
  always_comb begin
    sticky_d = clear ? '0 : sticky_q;
    count_d  = clear ? '0 : count_q;
    if (monitoring) begin
      sticky_d = sticky_d | sync_lo_q;
      if (fault_rise && (count_d != 8'hFF)) count_d = count_d + 8'd1;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_pend_q) begin
      case (rd_sel_q)
        2'd0: rd_data_d = 8'(sticky_q);
        2'd1: rd_data_d = count_q;
        2'd2: rd_data_d = {6'b0, state_q};
        2'd3: rd_data_d = 8'(sync_lo_q);
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      sticky_q  <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_sel_q  <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      sticky_q  <= sticky_d;
      count_q   <= count_d;
      rd_pend_q <= rd_req;
      rd_sel_q  <= rd_sel;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_pend_q;
    end
  end

endmodule

// File: tb/tb_sparecell_tie_monitor.sv
// Scoreboard bench for sparecell_tie_monitor: a behavioural model queues expected
// read data; a monitor pops and compares on every rd_ack and checks armed/fault_irq each cycle.
module tb_sparecell_tie_monitor;

  localparam int NS = 4;
  localparam int SC = 16;

  logic          clock    = 1'b0;
  logic          resetn   = 1'b0;
  logic [NS-1:0] spare_lo = '0;
  logic          enable   = 1'b0;
  logic          clear    = 1'b0;
  logic          rd_req   = 1'b0;
  logic [1:0]    rd_sel   = '0;
  logic [7:0]    rd_data;
  logic          rd_ack, armed, fault_irq;

  int n_checks = 0;
  int n_pass   = 0;

  sparecell_tie_monitor #(.NUM_SPARE(NS), .SETTLE_CYCLES(SC)) dut (
    .clock(clock), .resetn(resetn), .spare_lo(spare_lo), .enable(enable),
    .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data),
    .rd_ack(rd_ack), .armed(armed), .fault_irq(fault_irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural reference model
  logic [NS-1:0] m_s1 = '0, m_s2 = '0, m_sticky = '0;
  int            m_mode = 0, m_elapsed = 0, m_cnt = 0;
  bit            m_prev = 0, m_pend = 0, m_ack = 0, m_any = 0, m_rise = 0;
  logic [1:0]    m_pend_sel = '0;
  logic [7:0]    exp_q[$];
  logic [7:0]    mon_last = '0;

  function automatic logic [7:0] model_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return 8'(m_sticky);
      2'd1:    return 8'(m_cnt);
      2'd2:    return 8'(m_mode);
      default: return 8'(m_s2);
    endcase
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_s1 = '0; m_s2 = '0; m_sticky = '0;
      m_mode = 0; m_elapsed = 0; m_cnt = 0;
      m_prev = 0; m_pend = 0; m_ack = 0;
      exp_q.delete();
    end else begin
      m_ack = m_pend;
      if (m_pend) exp_q.push_back(model_read(m_pend_sel));
      m_pend = rd_req;
      m_pend_sel = rd_sel;
      m_any  = (m_s2 != 0);
      m_rise = m_any && !m_prev;
      if (clear) begin
        m_sticky = '0;
        m_cnt    = 0;
      end
      if (m_mode >= 2) begin
        m_sticky = m_sticky | m_s2;
        if (m_rise && m_cnt < 255) m_cnt++;
      end
      if (!enable) m_mode = 0;
      else begin
        case (m_mode)
          0: begin m_mode = 1; m_elapsed = 0; end
          1: begin m_elapsed++; if (m_elapsed == SC) m_mode = 2; end
          2: if (m_any) m_mode = 3;
          default: if (clear && !m_any) m_mode = 2;
        endcase
      end
      m_prev = m_any;
      m_s2 = m_s1;
      m_s1 = spare_lo;
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge
  always @(negedge clock) begin
    if (!resetn) mon_last = '0;
    else begin
      check("rd_ack", rd_ack, m_ack);
      if (rd_ack && exp_q.size() > 0) begin
        mon_last = exp_q.pop_front();
        check("rd_data", rd_data, mon_last);
      end else if (!rd_ack) begin
        check("rd_data_hold", rd_data, mon_last);
      end
      check("armed", armed, m_mode >= 2);
      check("fault_irq", fault_irq, m_mode == 3);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_read(input logic [1:0] sel, input logic [7:0] exp, input string name);
    bit got = 0;
    @(negedge clock);
    rd_req = 1'b1;
    rd_sel = sel;
    @(negedge clock);
    rd_req = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clock);
      #1;
      if (rd_ack) begin
        got = 1;
        check(name, rd_data, exp);
      end
    end
    check({name, "_ack"}, got, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cycles(2);
    #1;
    check("reset_rd_data", rd_data, 8'h00);
    check("reset_rd_ack", rd_ack, 0);
    check("reset_armed", armed, 0);
    check("reset_fault_irq", fault_irq, 0);
    #1 resetn = 1'b1;
    do_read(2'd2, 8'h00, "idle_state");

    // Settle window: armed rises exactly 17 edges after enable
    @(negedge clock);
    enable = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      n++;
      #1;
      if (armed) break;
    end
    check("settle_edges", n, 17);
    do_read(2'd2, 8'h02, "armed_state");

    // Three-cycle pulse on bit 2
    @(negedge clock);
    spare_lo = 4'b0100;
    n = 0;
    while (n < 10) begin
      @(posedge clock);
      n++;
      #1;
      if (fault_irq) break;
    end
    check("fault_latency", n, 3);
    @(negedge clock);
    spare_lo = '0;
    cycles(4);
    do_read(2'd0, 8'h04, "sticky_bit2");
    do_read(2'd1, 8'h01, "count_one");

    // Counter saturation, then clear with no fault present
    repeat (300) begin
      @(negedge clock) spare_lo = 4'b0001;
      @(negedge clock) spare_lo = 4'b0000;
    end
    cycles(4);
    do_read(2'd1, 8'hFF, "count_saturated");
    do_read(2'd0, 8'h05, "sticky_bits_0_2");
    @(negedge clock) clear = 1'b1;
    @(negedge clock) clear = 1'b0;
    cycles(1);
    do_read(2'd1, 8'h00, "count_cleared");
    do_read(2'd0, 8'h00, "sticky_cleared");
    do_read(2'd2, 8'h02, "rearmed_state");

    // Enter FAULT, remove the fault, then clear coinciding with a new edge
    @(negedge clock) spare_lo = 4'b1000;
    cycles(2);
    spare_lo = '0;
    cycles(4);
    do_read(2'd2, 8'h03, "fault_held");
    @(negedge clock) spare_lo = 4'b0010;
    cycles(2);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    spare_lo = '0;
    cycles(4);
    do_read(2'd2, 8'h03, "clear_vs_edge_state");
    do_read(2'd1, 8'h01, "clear_vs_edge_count");
    do_read(2'd0, 8'h02, "clear_vs_edge_sticky");

    // Reset in FAULT with a read in flight
    check("fault_before_reset", fault_irq, 1);
    @(negedge clock);
    rd_req = 1'b1;
    rd_sel = 2'd1;
    @(negedge clock);
    rd_req = 1'b0;
    #1 resetn = 1'b0;
    enable = 1'b0;
    #1;
    check("async_rst_rd_data", rd_data, 8'h00);
    check("async_rst_rd_ack", rd_ack, 0);
    check("async_rst_armed", armed, 0);
    check("async_rst_fault_irq", fault_irq, 0);
    cycles(2);
    #2 resetn = 1'b1;
    n = 0;
    repeat (4) begin
      @(posedge clock);
      #1;
      if (rd_ack) n++;
    end
    check("no_ack_after_reset", n, 0);

    // Fault present throughout SETTLE
    @(negedge clock) spare_lo = 4'b0001;
    cycles(3);
    enable = 1'b1;
    do_read(2'd0, 8'h00, "settle_sticky");
    do_read(2'd1, 8'h00, "settle_count");
    do_read(2'd2, 8'h01, "settle_state");
    n = 0;
    while (n < 30) begin
      @(posedge clock);
      n++;
      #1;
      if (armed) break;
    end
    check("settle_reaches_armed", armed, 1);
    @(posedge clock);
    #1;
    check("fault_after_armed", fault_irq, 1);
    do_read(2'd1, 8'h00, "settle_no_count");
    @(negedge clock) spare_lo = '0;

    // Randomized traffic checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      enable = ($urandom_range(63) != 0);
      clear  = ($urandom_range(15) == 0);
      rd_req = 1'($urandom_range(1));
      rd_sel = 2'($urandom_range(3));
      if ($urandom_range(7) == 0)
        spare_lo = $urandom_range(1) ? '0 : NS'($urandom_range(15));
    end
    @(negedge clock);
    rd_req = 1'b0;
    clear = 1'b0;
    cycles(5);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
